// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences challenge/trigger timing for an XOR PUF core,
// fires it VOTES times, majority-votes the synchronised response and
// returns the voted bit, a stability flag and the ones count.
module puf_eval_ctrl #(
   parameter int CHAL_W     = 8,
   parameter int SETUP_CYC  = 4,
   parameter int SETTLE_CYC = 8,
   parameter int RESET_CYC  = 4,
   parameter int VOTES      = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CHAL_W-1:0] req_challenge,
   output logic              puf_trigger,
   output logic [CHAL_W-1:0] puf_challenge,
   input  logic              puf_response,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_bit,
   output logic              rsp_stable,
   output logic [3:0]        rsp_ones,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, SETUP, FIRE, RECOVER, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] cyc_cnt, cyc_nxt;
   logic [3:0] eval_cnt, eval_nxt;
   logic [3:0] ones, ones_nxt;
   logic       sync1, sync2;
   logic       accept;

   assign rsp_ones = ones;

   // Two-flop synchroniser for the asynchronous arbiter output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= puf_response;
         sync2 <= sync1;
      end
   end

   // Next-state, counter updates and state-decoded handshake outputs.
   // SETUP spans SETUP_CYC+1 cycles: the first absorbs the challenge
   // register update so the core sees SETUP_CYC full cycles of a settled
   // challenge with trigger low before the first rise.
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc_cnt;
      eval_nxt  = eval_cnt;
      ones_nxt  = ones;
      accept    = 1'b0;
      req_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = SETUP;
               cyc_nxt   = 8'd0;
               eval_nxt  = 4'd0;
               ones_nxt  = 4'd0;
            end
         end
         SETUP: begin
            if (cyc_cnt == 8'(SETUP_CYC)) begin
               state_nxt = FIRE;
               cyc_nxt   = 8'd0;
            end else begin
               cyc_nxt = cyc_cnt + 8'd1;
            end
         end
         FIRE: begin
            if (cyc_cnt == 8'(SETTLE_CYC - 1)) begin
               state_nxt = RECOVER;
               cyc_nxt   = 8'd0;
               eval_nxt  = eval_cnt + 4'd1;
               ones_nxt  = ones + {3'b000, sync2};
            end else begin
               cyc_nxt = cyc_cnt + 8'd1;
            end
         end
         RECOVER: begin
            if (cyc_cnt == 8'(RESET_CYC - 1)) begin
               cyc_nxt   = 8'd0;
               state_nxt = (eval_cnt < 4'(VOTES)) ? FIRE : DONE;
            end else begin
               cyc_nxt = cyc_cnt + 8'd1;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and the glitch-free registered core drive lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cyc_cnt       <= 8'd0;
         eval_cnt      <= 4'd0;
         ones          <= 4'd0;
         puf_trigger   <= 1'b0;
         puf_challenge <= '0;
      end else begin
         state       <= state_nxt;
         cyc_cnt     <= cyc_nxt;
         eval_cnt    <= eval_nxt;
         ones        <= ones_nxt;
         puf_trigger <= (state_nxt == FIRE);
         if (accept) puf_challenge <= req_challenge;
      end
   end

   // Vote result: cleared at acceptance, resolved on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_bit    <= 1'b0;
         rsp_stable <= 1'b0;
      end else if (accept) begin
         rsp_bit    <= 1'b0;
         rsp_stable <= 1'b0;
      end else if (state == RECOVER && state_nxt == DONE) begin
         rsp_bit    <= (ones > 4'(VOTES / 2));
         rsp_stable <= (ones == 4'd0) || (ones == 4'(VOTES));
      end
   end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Bench for puf_eval_ctrl: vote tables, random votes against a popcount
// model, trigger waveform shape, backpressure, mid-run reset, back-to-back.
module tb_puf_eval_ctrl;

   localparam int VOTES = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_challenge = 8'h00;
   logic       puf_trigger;
   logic [7:0] puf_challenge;
   logic       puf_response = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic       rsp_bit;
   logic       rsp_stable;
   logic [3:0] rsp_ones;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;

   puf_eval_ctrl #(.CHAL_W(8), .SETUP_CYC(4), .SETTLE_CYC(8), .RESET_CYC(4), .VOTES(VOTES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
      .puf_trigger(puf_trigger), .puf_challenge(puf_challenge), .puf_response(puf_response),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_bit(rsp_bit), .rsp_stable(rsp_stable), .rsp_ones(rsp_ones), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: majority vote over the per-pulse responses
   function automatic logic [5:0] model(input logic [4:0] pat);
      int o;
      o = $countones(pat);
      return {(o > VOTES / 2) ? 1'b1 : 1'b0, (o == 0 || o == VOTES) ? 1'b1 : 1'b0, 4'(o)};
   endfunction

   // One request: pat[k] is the response for pulse k; hold = DONE stall cycles
   task automatic run_req(input logic [7:0] chal, input logic [4:0] pat, input int hold,
                          output logic got_bit, output logic got_stab, output logic [3:0] got_ones);
      int   wave_err, chal_err, vld_err, bp_err, pulse, t;
      logic prev_trig;
      logic [7:0] s_chal;
      wave_err = 0; chal_err = 0; vld_err = 0; bp_err = 0; pulse = 0; prev_trig = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_challenge = chal; rsp_ready = 1'b0;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      if (!req_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_challenge = ~chal;
      for (int i = 0; i <= 64; i++) begin
         if (puf_trigger !== ((i >= 5) && ((i - 5) % 12 < 8))) wave_err++;
         if (puf_challenge !== chal) chal_err++;
         if (rsp_valid !== 1'b0) vld_err++;
         if (puf_trigger && !prev_trig && pulse < VOTES) begin
            puf_response = pat[pulse];
            pulse++;
         end
         prev_trig = puf_trigger;
         @(negedge clk);
      end
      puf_response = 1'b0;
      chk("trigger_waveform_errs", wave_err, 0);
      chk("challenge_hold_errs", chal_err, 0);
      chk("early_rsp_valid_errs", vld_err, 0);
      chk("rsp_valid_at_edge65", rsp_valid, 1);
      chk("req_ready_in_done", req_ready, 0);
      got_bit = rsp_bit; got_stab = rsp_stable; got_ones = rsp_ones; s_chal = puf_challenge;
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'($urandom); req_challenge = 8'($urandom);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_bit !== got_bit || rsp_stable !== got_stab ||
             rsp_ones !== got_ones || req_ready !== 1'b0 || puf_challenge !== s_chal ||
             puf_trigger !== 1'b0 || busy !== 1'b1) bp_err++;
      end
      if (hold > 0) chk("backpressure_errs", bp_err, 0);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_handshake_idle", {rsp_valid, req_ready, busy}, 3'b010);
      chk("ones_held_in_idle", rsp_ones, got_ones);
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0] chal;
      logic [4:0] pat;
      int         hold;
      logic       exp_bit;
      logic       exp_stab;
      logic [3:0] exp_ones;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic       b, s;
      logic [3:0] o;
      logic [5:0] m;
      logic [4:0] rp;
      int         err, t;
      logic [7:0] prev_chal;

      vecs[0] = '{8'hA5, 5'b11111, 0,  1'b1, 1'b1, 4'd5};
      vecs[1] = '{8'h5A, 5'b10101, 0,  1'b1, 1'b0, 4'd3};
      vecs[2] = '{8'h11, 5'b10100, 0,  1'b0, 1'b0, 4'd2};
      vecs[3] = '{8'hFF, 5'b00000, 0,  1'b0, 1'b1, 4'd0};
      vecs[4] = '{8'h3E, 5'b01110, 20, 1'b1, 1'b0, 4'd3};

      // Reset state and quiet idle
      #12;
      chk("reset_outputs", {puf_trigger, puf_challenge, rsp_valid, rsp_bit, rsp_stable, rsp_ones, busy, req_ready},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1});
      @(negedge clk); rst_n = 1'b1;
      err = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (puf_trigger !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) err++;
      end
      chk("idle_100_cycles", err, 0);

      // Directed vote table
      foreach (vecs[k]) begin
         run_req(vecs[k].chal, vecs[k].pat, vecs[k].hold, b, s, o);
         chk($sformatf("vec%0d_bit", k), b, vecs[k].exp_bit);
         chk($sformatf("vec%0d_stable", k), s, vecs[k].exp_stab);
         chk($sformatf("vec%0d_ones", k), o, vecs[k].exp_ones);
      end

      // Random votes against the model
      for (int r = 0; r < 8; r++) begin
         rp = 5'($urandom);
         m  = model(rp);
         run_req(8'($urandom), rp, $urandom_range(0, 3), b, s, o);
         chk($sformatf("rand%0d_result", r), {b, s, o}, m);
      end

      // Reset during the third pulse
      @(negedge clk);
      req_valid = 1'b1; req_challenge = 8'h77;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 1; i <= 31; i++) @(negedge clk);
      chk("third_pulse_high", puf_trigger, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_trigger_drop", {puf_trigger, busy, req_ready}, 3'b001);
      @(negedge clk); rst_n = 1'b1;
      rsp_ready = 1'b1;
      err = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || puf_trigger !== 1'b0) err++;
      end
      chk("no_rsp_after_abort", err, 0);
      rsp_ready = 1'b0;
      run_req(8'h77, 5'b11011, 0, b, s, o);
      chk("post_abort_result", {b, s, o}, model(5'b11011));

      // Back-to-back with rsp_ready tied high
      @(negedge clk);
      rsp_ready = 1'b1; req_valid = 1'b1; req_challenge = 8'h3C; puf_response = 1'b1;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      @(negedge clk);
      req_challenge = 8'hC3;
      err = 0;
      prev_chal = puf_challenge;
      for (int e = 1; e <= 134; e++) begin
         @(negedge clk);
         if (puf_trigger && puf_challenge !== prev_chal) err++;
         prev_chal = puf_challenge;
         if (e == 64) chk("b2b_first_not_yet", rsp_valid, 0);
         if (e == 65) chk("b2b_first_done", rsp_valid, 1);
         if (e == 66) chk("b2b_idle_after_hs", {req_ready, puf_challenge}, {1'b1, 8'h3C});
         if (e == 67) begin
            chk("b2b_second_accept", {busy, puf_challenge}, {1'b1, 8'hC3});
            req_valid = 1'b0;
         end
         if (e == 131) chk("b2b_second_not_yet", rsp_valid, 0);
         if (e == 132) chk("b2b_second_done", {rsp_valid, rsp_bit, rsp_stable, rsp_ones}, {3'b111, 4'd5});
      end
      chk("b2b_chal_stable_in_pulse", err, 0);
      rsp_ready = 1'b0; puf_response = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
Sequencing controller for the 8-bit XOR PUF core. It accepts a challenge over a valid/ready request port and drives the challenge and trigger lines with programmed setup, settle and recovery timing. It fires the PUF VOTES times, synchronises and majority-votes the asynchronous response, then returns a voted bit plus a stability flag over a valid/ready response port. It sits between the on-chip host logic and the XOR PUF core instance.

Parameters:
CHAL_W, 8, challenge width; must match the PUF core.
SETUP_CYC, 4, cycles the challenge is held with trigger low before the first trigger rise; legal range 1..255.
SETTLE_CYC, 8, cycles trigger is held high per evaluation; the response is sampled in the last of these cycles; legal range 3..255.
RESET_CYC, 4, cycles trigger is held low between evaluations and after the last one; legal range 1..255.
VOTES, 5, evaluations per request; must be odd, legal range 1..15.

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  requester has a challenge
req_ready  out  1  controller idle; request accepted when valid&&ready
req_challenge  in  CHAL_W  challenge; sampled only at acceptance
puf_trigger  out  1  trigger to the PUF core; registered, glitch-free
puf_challenge  out  CHAL_W  challenge to the PUF core; registered
puf_response  in  1  PUF response; asynchronous to clk
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts the result
rsp_bit  out  1  majority-voted response
rsp_stable  out  1  all VOTES samples agreed
rsp_ones  out  4  count of samples equal to 1
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; puf_trigger=0, puf_challenge=0, rsp_valid=0, rsp_bit=0, rsp_stable=0, rsp_ones=0, busy=0, req_ready=1. Counters and synchroniser flops are cleared.
- puf_response passes through a 2-flop synchroniser. SETTLE_CYC>=3 guarantees the sampled value reflects the arbiter decision.
- FSM:
  - IDLE: req_ready=1. On req_valid, latch req_challenge into puf_challenge, clear the vote counters, and go to SETUP.
  - SETUP: trigger=0 for SETUP_CYC cycles, then go to FIRE.
  - FIRE: trigger=1 for SETTLE_CYC cycles. On the edge leaving FIRE, capture the synchronised response. Increment eval_cnt, and increment rsp_ones if the response is 1. Then go to RECOVER.
  - RECOVER: trigger=0 for RESET_CYC cycles. If eval_cnt<VOTES go to FIRE, else go to DONE.
  - DONE: rsp_valid=1. rsp_bit = (ones > VOTES/2). rsp_stable = (ones==0 || ones==VOTES). On rsp_ready, go to IDLE.
- Latency: DONE is entered on rising edge N after the accepting edge, where N = 1 + SETUP_CYC + VOTES*(SETTLE_CYC+RESET_CYC). With default parameters N = 65.
- Result outputs: rsp_bit, rsp_stable and rsp_ones are stable for the whole DONE state. They hold their last values in IDLE and are cleared only by reset or by the next acceptance (rsp_ones clears to 0).
- puf_challenge holds its value from acceptance until the next acceptance; it never changes while puf_trigger=1.
- puf_trigger pulses: exactly VOTES pulses per request, each exactly SETTLE_CYC cycles wide, with low gaps of exactly RESET_CYC cycles.
- req_ready=0 outside IDLE. req_valid is ignored there, and no request is lost or queued.
- Back-to-back requests: the rsp handshake edge returns the FSM to IDLE, so the next request can be accepted on the following edge.
- Backpressure: rsp_ready low holds DONE indefinitely with all outputs constant and puf_trigger=0.
- Reset asserted mid-operation (any state) forces trigger low asynchronously. No response is produced for the aborted request.

Test Plan:
1. Assert rst_n=0 then release → all outputs 0, req_ready=1, busy=0; puf_trigger stays 0 for 100 idle cycles.
2. Request challenge 0xA5 with the PUF model always returning 1 → puf_challenge=0xA5 one edge after acceptance; 5 trigger pulses, each 8 cycles high with 4-cycle gaps; rsp_valid on edge 65; rsp_bit=1, rsp_ones=5, rsp_stable=1.
3. PUF model sequence 1,0,1,0,1 → rsp_bit=1, rsp_ones=3, rsp_stable=0. Sequence 0,0,1,0,1 → rsp_bit=0, rsp_ones=2, rsp_stable=0.
4. Hold rsp_ready=0 for 20 cycles in DONE while toggling req_valid and req_challenge → rsp outputs constant, req_ready=0, puf_challenge unchanged, and no new acceptance occurs.
5. Pull rst_n low during the 3rd FIRE pulse → puf_trigger drops before the next clock edge; state returns to IDLE, rsp_valid never asserts, and the next request completes normally.
6. Two requests back to back (0x3C then 0xC3) with rsp_ready tied high → the second request is accepted on the edge after the first response handshake, and puf_challenge=0xC3 is never changed while puf_trigger=1.
